// File: rtl/irq_controller.sv
// Edge-triggered, maskable, fixed-priority interrupt controller for the pipelined MIPS CPU.
// Define IRQ_STATS_EN to add per-source saturating take counters read through address 3.
module irq_controller #(
  parameter int          N_SRC        = 4,
  parameter logic [31:0] HANDLER_ADDR = 32'h8000_0004,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             pipe_safe,
  input  logic             kernel_mode,
  input  logic             eret,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             take_irq,
  output logic [31:0]      handler_pc,
  output logic [2:0]       irq_id,
  output logic             in_svc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SVC   = 2'd2
  } state_t;

  state_t           state_q;
  logic [2:0]       irqId_q;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] w1cBits;
  logic [N_SRC-1:0] takeClr;
  logic [7:0]       activeExt;
  logic [7:0]       idHot;
  logic [2:0]       winner;
  logic             anyActive;
  logic             unusedWdata;

  assign unusedWdata = ^cfg_wdata;

  assign rise      = irq_src & ~prev_q;
  assign active    = pending_q & mask_q;
  assign anyActive = |active;
  assign activeExt = 8'(active);
  assign idHot     = 8'd1 << irqId_q;

  // The held id must still be enabled and pending this very cycle, so a mask
  // write or W1C landing while ARMED can never let a disabled source through.
  assign take_irq   = (state_q == ARMED) && pipe_safe && !kernel_mode && activeExt[irqId_q];
  assign in_svc     = (state_q == SVC);
  assign irq_id     = irqId_q;
  assign handler_pc = HANDLER_ADDR;

  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) winner = 3'(i);
    end
  end

  // A fresh rise is OR-ed in last so it beats both the W1C and the take clear.
  always_comb begin
    w1cBits   = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[N_SRC-1:0] : '0;
    takeClr   = take_irq ? idHot[N_SRC-1:0] : '0;
    pending_d = (pending_q & ~w1cBits & ~takeClr) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      prev_q    <= irq_src;
      pending_q <= pending_d;
      if (cfg_we && cfg_addr == 2'd0) mask_q <= cfg_wdata[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      irqId_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyActive && !kernel_mode) begin
            state_q <= ARMED;
            irqId_q <= winner;
          end
        end
        ARMED: begin
          if (take_irq) begin
            state_q <= SVC;
          end else if (!anyActive) begin
            state_q <= IDLE;
          end else begin
            irqId_q <= winner;
          end
        end
        SVC: begin
          if (eret) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IRQ_STATS_EN
  logic [2:0]       statSel_q;
  logic [CNT_W-1:0] cnt_q [N_SRC];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      statSel_q <= '0;
    end else if (cfg_we && cfg_addr == 2'd0) begin
      statSel_q <= cfg_wdata[10:8];
    end
  end

  // Clearing through address 3 also swallows a take landing in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
    end else if (cfg_we && cfg_addr == 2'd3) begin
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
    end else if (take_irq) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (irqId_q == 3'(i) && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end
`endif

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: begin
        cfg_rdata[N_SRC-1:0] = mask_q;
`ifdef IRQ_STATS_EN
        cfg_rdata[10:8] = statSel_q;
`endif
      end
      2'd1: cfg_rdata[N_SRC-1:0] = pending_q;
      2'd2: cfg_rdata[3:0] = {in_svc, irqId_q};
      2'd3: begin
`ifdef IRQ_STATS_EN
        for (int i = 0; i < N_SRC; i++) begin
          if (statSel_q == 3'(i)) cfg_rdata[CNT_W-1:0] = cnt_q[i];
        end
`endif
      end
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed, self-checking bench for irq_controller: a table of single-pulse take
// scenarios plus hand-written sequences for reset, priority, stalls, kernel mode and stats.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_src;
  logic        pipe_safe;
  logic        kernel_mode;
  logic        eret;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        take_irq;
  logic [31:0] handler_pc;
  logic [2:0]  irq_id;
  logic        in_svc;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] src;
    logic [2:0] expId;
    logic [3:0] expPend;
  } vec_t;

  vec_t vecs[6];

  irq_controller #(.N_SRC(4), .HANDLER_ADDR(32'h8000_0004), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .pipe_safe(pipe_safe),
    .kernel_mode(kernel_mode), .eret(eret), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .take_irq(take_irq),
    .handler_pc(handler_pc), .irq_id(irq_id), .in_svc(in_svc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic cfgWrite(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    irq_src = '0;
    pipe_safe = 1'b1;
    kernel_mode = 1'b0;
    eret = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulseEret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [31:0] d;
    doReset();
    cfgWrite(2'd0, {28'b0, v.mask});
    irq_src = v.src;
    tick();
    irq_src = '0;
    checkOutput($sformatf("vec%0d take before latency", idx), {31'b0, take_irq}, 32'd0);
    tick();
    checkOutput($sformatf("vec%0d take", idx), {31'b0, take_irq}, 32'd1);
    checkOutput($sformatf("vec%0d irq_id", idx), {29'b0, irq_id}, {29'b0, v.expId});
    tick();
    checkOutput($sformatf("vec%0d take after", idx), {31'b0, take_irq}, 32'd0);
    readReg(2'd1, d);
    checkOutput($sformatf("vec%0d pending", idx), d, {28'b0, v.expPend});
    readReg(2'd2, d);
    checkOutput($sformatf("vec%0d cause", idx), d, {28'b0, 1'b1, v.expId});
    pulseEret();
    checkOutput($sformatf("vec%0d in_svc after eret", idx), {31'b0, in_svc}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int takes;

    vecs[0] = '{mask: 4'b1111, src: 4'b0100, expId: 3'd2, expPend: 4'b0000};
    vecs[1] = '{mask: 4'b1111, src: 4'b1100, expId: 3'd2, expPend: 4'b1000};
    vecs[2] = '{mask: 4'b1010, src: 4'b0111, expId: 3'd1, expPend: 4'b0101};
    vecs[3] = '{mask: 4'b1000, src: 4'b1001, expId: 3'd3, expPend: 4'b0001};
    vecs[4] = '{mask: 4'b0110, src: 4'b1110, expId: 3'd1, expPend: 4'b1100};
    vecs[5] = '{mask: 4'b1111, src: 4'b0101, expId: 3'd0, expPend: 4'b0100};

    doReset();
    checkOutput("handler_pc", handler_pc, 32'h8000_0004);

    // Reset asserted in the middle of a service with a second request pending.
    cfgWrite(2'd0, 32'h3);
    irq_src = 4'b0001;
    tick();
    irq_src = '0;
    tick();
    tick();
    irq_src = 4'b0010;
    tick();
    irq_src = '0;
    checkOutput("pre-reset in_svc", {31'b0, in_svc}, 32'd1);
    readReg(2'd1, d);
    checkOutput("pre-reset pending", d, 32'h2);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("reset take_irq", {31'b0, take_irq}, 32'd0);
    checkOutput("reset in_svc", {31'b0, in_svc}, 32'd0);
    checkOutput("reset irq_id", {29'b0, irq_id}, 32'd0);
    readReg(2'd0, d);
    checkOutput("reset mask", d, 32'd0);
    readReg(2'd1, d);
    checkOutput("reset pending", d, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    readReg(2'd2, d);
    checkOutput("post-reset cause", d, 32'd0);
    checkOutput("post-reset take", {31'b0, take_irq}, 32'd0);

    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    // Two simultaneous rises: lower index first, the other right after eret.
    doReset();
    cfgWrite(2'd0, 32'h3);
    irq_src = 4'b0011;
    tick();
    irq_src = '0;
    tick();
    checkOutput("prio first take", {31'b0, take_irq}, 32'd1);
    checkOutput("prio first id", {29'b0, irq_id}, 32'd0);
    tick();
    pulseEret();
    checkOutput("prio idle gap", {31'b0, take_irq}, 32'd0);
    tick();
    checkOutput("prio second take", {31'b0, take_irq}, 32'd1);
    checkOutput("prio second id", {29'b0, irq_id}, 32'd1);
    tick();
    pulseEret();
    takes = 0;
    for (int i = 0; i < 5; i++) begin
      if (take_irq) takes++;
      tick();
    end
    checkOutput("prio no third take", takes, 32'd0);

    // Stalled pipeline, then the source is masked off and re-enabled.
    doReset();
    cfgWrite(2'd0, 32'h2);
    pipe_safe = 1'b0;
    irq_src = 4'b0010;
    tick();
    irq_src = '0;
    tick();
    takes = 0;
    for (int i = 0; i < 10; i++) begin
      if (take_irq) takes++;
      tick();
    end
    checkOutput("stall no take", takes, 32'd0);
    cfgWrite(2'd0, 32'h0);
    pipe_safe = 1'b1;
    #1;
    checkOutput("masked take", {31'b0, take_irq}, 32'd0);
    tick();
    readReg(2'd1, d);
    checkOutput("masked pending kept", d, 32'h2);
    checkOutput("masked in_svc", {31'b0, in_svc}, 32'd0);
    cfgWrite(2'd0, 32'h2);
    checkOutput("reenable early take", {31'b0, take_irq}, 32'd0);
    tick();
    checkOutput("reenable take", {31'b0, take_irq}, 32'd1);
    checkOutput("reenable id", {29'b0, irq_id}, 32'd1);

    // Kernel mode blocks entry; set beats W1C; a held level sets pending once.
    doReset();
    cfgWrite(2'd0, 32'h1);
    kernel_mode = 1'b1;
    irq_src = 4'b0001;
    tick();
    irq_src = '0;
    takes = 0;
    for (int i = 0; i < 4; i++) begin
      if (take_irq || in_svc) takes++;
      tick();
    end
    checkOutput("kernel no take", takes, 32'd0);
    irq_src = 4'b0001;
    cfg_we = 1'b1;
    cfg_addr = 2'd1;
    cfg_wdata = 32'h1;
    tick();
    cfg_we = 1'b0;
    readReg(2'd1, d);
    checkOutput("set beats w1c", d, 32'h1);
    cfgWrite(2'd1, 32'h1);
    tick();
    readReg(2'd1, d);
    checkOutput("held level no reset", d, 32'h0);
    irq_src = '0;

`ifdef IRQ_STATS_EN
    doReset();
    cfgWrite(2'd0, 32'h204);
    readReg(2'd0, d);
    checkOutput("stat select readback", d, 32'h204);
    for (int n = 0; n < 5; n++) begin
      irq_src = 4'b0100;
      tick();
      irq_src = '0;
      tick();
      checkOutput($sformatf("stats take %0d", n), {31'b0, take_irq}, 32'd1);
      tick();
      pulseEret();
      if (n == 0) begin
        readReg(2'd3, d);
        checkOutput("stats count one", d, 32'd1);
      end
    end
    readReg(2'd3, d);
    checkOutput("stats saturated", d, 32'd3);
    cfgWrite(2'd3, 32'h0);
    readReg(2'd3, d);
    checkOutput("stats cleared", d, 32'd0);
`else
    doReset();
    cfgWrite(2'd0, 32'hFFFF_FFFF);
    readReg(2'd0, d);
    checkOutput("mask unused bits", d, 32'hF);
    readReg(2'd3, d);
    checkOutput("addr3 reads zero", d, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
